// File: rtl/uart_defs_pkg.sv
// Shared definitions for the frame UART transmitter: FSM encoding and line-format constants.
package uart_defs_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int CLK_DIV_DEFAULT = 434;

endpackage

// File: rtl/frame_uart_tx_byte_fifo.sv
// Byte FIFO with occupancy count; a write into a full FIFO is accepted only alongside a pop.
module byte_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          pop,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic [AW:0]   cnt,
  output logic          drop
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          accept;

  assign empty   = (cnt_q == '0);
  assign cnt     = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];
  // When full, the pop frees the head slot, which is exactly where wr_ptr points.
  assign accept  = wr_en & ((cnt_q != DEPTH_CNT) | pop);
  assign drop    = wr_en & ~accept;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (accept) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_uart_tx.sv
// Buffers frame-output bytes and serialises them as UART 8N1, LSB first, with overflow flag.
// state | meaning: IDLE line idle | START start bit | DATA data bits | STOP stop bit
module frame_uart_tx
  import uart_defs_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic             den,
  input  logic             ovf_clr,
  output logic             txd,
  output logic             busy,
  output logic             ovf,
  output logic [FIFO_AW:0] fifo_cnt
);

  localparam logic [15:0] BAUD_TC  = 16'(CLK_DIV - 1);
  localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sr_q, sr_d;
  logic        txd_q, txd_d;
  logic        ovf_q, ovf_d;

  logic        pop;
  logic        baud_tc;
  logic        fifo_empty;
  logic        fifo_drop;
  logic [7:0]  fifo_head;

  byte_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (den),
    .wr_data (din),
    .pop     (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .cnt     (fifo_cnt),
    .drop    (fifo_drop)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    baud_tc = (baud_q == BAUD_TC);
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sr_d    = fifo_head;
          txd_d   = 1'b0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = sr_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            sr_d  = {1'b0, sr_q[7:1]};
            txd_d = sr_q[1];
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_tc) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            sr_d    = fifo_head;
            txd_d   = 1'b0;
            state_d = S_START;
          end else begin
            txd_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (fifo_drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign txd  = txd_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != S_IDLE) | (fifo_cnt != '0);

endmodule

// File: tb/tb_frame_uart_tx.sv
// Bench for frame_uart_tx: per-cycle queue/timeline model, independent line decoder, directed tests.
module tb_frame_uart_tx;

  localparam int DIV   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          den = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          txd, busy, ovf;
  logic [AW:0]   fifo_cnt;

  int checks = 0;
  int errors = 0;
  int peak   = 0;

  always #5 clk = ~clk;

  frame_uart_tx #(.CLK_DIV(DIV), .FIFO_AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .den      (den),
    .ovf_clr  (ovf_clr),
    .txd      (txd),
    .busy     (busy),
    .ovf      (ovf),
    .fifo_cnt (fifo_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte queue plus "cycles left in the frame on the line".
  logic [7:0] m_q[$];
  int         m_rem = 0;
  logic [7:0] m_cur = 8'h00;
  logic       m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
    end else begin
      bit pop_now;
      bit acc;
      pop_now = (m_rem <= 1) && (m_q.size() > 0);
      acc     = den && ((m_q.size() < DEPTH) || pop_now);
      if (pop_now) begin
        m_cur = m_q.pop_front();
        m_rem = FRAME;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (acc) m_q.push_back(din);
      if (den && !acc) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  function automatic logic exp_txd();
    int k;
    if (m_rem == 0) return 1'b1;
    k = (FRAME - m_rem) / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    chk("txd", {31'd0, txd}, {31'd0, exp_txd()});
    chk("busy", {31'd0, busy}, {31'd0, (m_rem != 0) || (m_q.size() != 0)});
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    chk("fifo_cnt", 32'(fifo_cnt), 32'(m_q.size()));
    if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
  end

  // Line decoder, samples mid-bit; independent of the model above.
  int         dcnt = 0;
  logic [7:0] dsr = 8'h00;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (rst) begin
      dcnt = 0;
    end else if (dcnt == 0) begin
      if (txd == 1'b0) dcnt = 1;
    end else begin
      dcnt++;
      if (dcnt >= 6 && dcnt <= 34 && ((dcnt - 6) % DIV) == 0) dsr[(dcnt-6)/DIV] = txd;
      if (dcnt == 38) begin
        chk("stop_bit", {31'd0, txd}, 32'd1);
        rx_q.push_back(dsr);
      end
      if (dcnt == FRAME) dcnt = 0;
    end
  end

  logic [7:0] stim[$];
  logic [7:0] exp_rx[$];

  task automatic send();
    foreach (stim[i]) begin
      den = 1'b1;
      din = stim[i];
      @(negedge clk);
    end
    den = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_rx();
    chk("rx_count", 32'(rx_q.size()), 32'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
      chk("rx_byte", {24'd0, rx_q[i]}, {24'd0, exp_rx[i]});
  endtask

  initial begin
    int n;
    int line_a5 [10];
    line_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte, exact line pattern and frame length
    rx_q.delete();
    stim = '{8'hA5};
    send();
    chk("t1_txd_pre", {31'd0, txd}, 32'd1);
    @(negedge clk);
    chk("t1_txd_fall", {31'd0, txd}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      chk("t1_bit", {31'd0, txd}, 32'(line_a5[k]));
      if (k < 9) repeat (DIV) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("t1_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_busy_drop", {31'd0, busy}, 32'd0);
    exp_rx = '{8'hA5};
    check_rx();

    // 2: three bytes back to back; last write at e+2, busy drops after e+121
    rx_q.delete();
    stim = '{8'h01, 8'h80, 8'hFF};
    send();
    wait_idle(n);
    chk("t2_cycles", 32'(n), 32'd119);
    chk("t2_ovf", {31'd0, ovf}, 32'd0);
    exp_rx = '{8'h01, 8'h80, 8'hFF};
    check_rx();

    // 3: six bytes, sixth dropped
    rx_q.delete();
    peak = 0;
    stim = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    send();
    chk("t3_ovf", {31'd0, ovf}, 32'd1);
    wait_idle(n);
    chk("t3_peak", 32'(peak), 32'd4);
    exp_rx = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    check_rx();

    // 6: ovf clear, then clear coinciding with a drop
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t6_ovf_clr", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      den     = 1'b1;
      din     = 8'(8'h40 + i);
      ovf_clr = (i == 5);
      @(negedge clk);
    end
    den = 1'b0;
    ovf_clr = 1'b0;
    chk("t6_ovf_same_edge", {31'd0, ovf}, 32'd1);
    wait_idle(n);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t6_ovf_clr2", {31'd0, ovf}, 32'd0);

    // 4: write on the STOP->START pop edge with the FIFO full
    rx_q.delete();
    stim = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    send();
    repeat (36) @(negedge clk);
    chk("t4_cnt_full", 32'(fifo_cnt), 32'd4);
    den = 1'b1;
    din = 8'h26;
    @(negedge clk);
    den = 1'b0;
    chk("t4_cnt", 32'(fifo_cnt), 32'd4);
    chk("t4_ovf", {31'd0, ovf}, 32'd0);
    wait_idle(n);
    exp_rx = '{8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    exp_rx.push_front(8'h21);
    check_rx();

    // 5: reset during data bit 3, then a clean frame
    rx_q.delete();
    stim = '{8'h55, 8'h66};
    send();
    repeat (17) @(negedge clk);
    chk("t5_cnt_pre", 32'(fifo_cnt), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_txd_rst", {31'd0, txd}, 32'd1);
    chk("t5_cnt_rst", 32'(fifo_cnt), 32'd0);
    chk("t5_busy_rst", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    @(negedge clk);
    stim = '{8'h3C};
    send();
    wait_idle(n);
    exp_rx = '{8'h3C};
    check_rx();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
